// File: rtl/vec_mul_result_checker.sv
// ---------------------------------------------------------------------------
// vec_mul_result_checker
//
// On-chip result scoreboard for the TOP_vec_mul family. A rising edge on
// end_ starts a check. The block waits SETTLE_CYCLES idle cycles and then
// walks row_count rows of the result SRAM, starting at base_address. Each
// row is compared, lane by lane, against an expected-value memory that is
// read at the same address. The block reports pass/fail, a saturating count
// of mismatching rows, and the address and lane mask of the first failing
// row.
//
// Optional feature macro: CHECK_LANE_MASK_EN
//   defined   : adds input lane_enable[MATRIX_SIZE-1:0], sampled at start.
//               Disabled lanes never count as mismatches.
//   undefined : the port is absent and every lane is compared.
//
// Ports
//   clk, rstn             clock, asynchronous active-low reset
//   end_                  level from multiplier; rising edge starts a check
//   abort                 synchronous abort back to IDLE (wins over start)
//   base_address          first row address, sampled at start
//   row_count             number of rows to check, sampled at start
//   lane_enable           (CHECK_LANE_MASK_EN only) per-lane compare enable
//   check_address         read address to result SRAM and expected memory
//   result_data           result row, READ_LATENCY cycles after the address
//   expected_data         expected row, READ_LATENCY cycles after the address
//   busy / done / pass    status; pass is valid while done
//   mismatch_count        mismatching rows, saturating
//   first_fail_valid      a failing row has been captured
//   first_fail_address    address of the first failing row
//   first_fail_lane_mask  lanes that mismatched in the first failing row
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module vec_mul_result_checker #(
    parameter int ADDRESSSIZE    = 10,
    parameter int PARTIAL_SUM_BW = 24,
    parameter int MATRIX_SIZE    = 16,
    parameter int SETTLE_CYCLES  = 2,
    parameter int READ_LATENCY   = 1
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic                                   end_,
    input  logic                                   abort,
    input  logic [ADDRESSSIZE-1:0]                 base_address,
    input  logic [ADDRESSSIZE:0]                   row_count,
`ifdef CHECK_LANE_MASK_EN
    input  logic [MATRIX_SIZE-1:0]                 lane_enable,
`endif
    output logic [ADDRESSSIZE-1:0]                 check_address,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0]  result_data,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0]  expected_data,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   pass,
    output logic [ADDRESSSIZE:0]                   mismatch_count,
    output logic                                   first_fail_valid,
    output logic [ADDRESSSIZE-1:0]                 first_fail_address,
    output logic [MATRIX_SIZE-1:0]                 first_fail_lane_mask
);

    localparam int LANE_W = PARTIAL_SUM_BW;
    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int DRN_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    // Counters run down to zero, so they are loaded with (length - 1).
    localparam logic [SET_W-1:0] SETTLE_LOAD =
        SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [DRN_W-1:0] DRAIN_LOAD  = DRN_W'(READ_LATENCY - 1);
    localparam logic [ADDRESSSIZE:0] ONE_ROW = {{ADDRESSSIZE{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic                     end_q;
    logic [ADDRESSSIZE-1:0]   base_q;
    logic [ADDRESSSIZE:0]     rows_left_q, rows_left_d;
    logic [ADDRESSSIZE-1:0]   addr_q, addr_d;
    logic [SET_W-1:0]         settle_q, settle_d;
    logic [DRN_W-1:0]         drain_q, drain_d;
    logic [READ_LATENCY-1:0]  vld_q, vld_d;
    logic [ADDRESSSIZE-1:0]   addr_pipe_q [READ_LATENCY];
`ifdef CHECK_LANE_MASK_EN
    logic [MATRIX_SIZE-1:0]   lane_en_q;
`endif

    logic                     start;
    logic                     accept;
    logic                     issue;
    logic                     clear_res;
    logic [MATRIX_SIZE-1:0]   lane_mis;
    logic                     row_bad;

    logic [ADDRESSSIZE:0]     mism_q;
    logic                     ffv_q;
    logic [ADDRESSSIZE-1:0]   ffa_q;
    logic [MATRIX_SIZE-1:0]   ffm_q;

    assign start = end_ && !end_q;

    // -----------------------------------------------------------------------
    // Control: next state, address walk, settle/drain counters
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rows_left_d = rows_left_q;
        addr_d      = addr_q;
        settle_d    = settle_q;
        drain_d     = drain_q;
        accept      = 1'b0;
        issue       = 1'b0;
        clear_res   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept      = 1'b1;
                    clear_res   = 1'b1;
                    rows_left_d = row_count;
                    if (row_count == '0) begin
                        state_d = S_DONE;
                    end else if (SETTLE_CYCLES == 0) begin
                        state_d = S_SCAN;
                        addr_d  = base_address;
                    end else begin
                        state_d  = S_SETTLE;
                        settle_d = SETTLE_LOAD;
                    end
                end
            end
            S_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = S_SCAN;
                    addr_d  = base_q;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            S_SCAN: begin
                issue       = 1'b1;
                rows_left_d = rows_left_q - 1'b1;
                if (rows_left_q == ONE_ROW) begin
                    // Last row issued: address holds, wait for its data.
                    state_d = S_DRAIN;
                    drain_d = DRAIN_LOAD;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort beats everything, including a start in the same cycle.
        if (abort) begin
            state_d   = S_IDLE;
            accept    = 1'b0;
            clear_res = 1'b1;
        end

        // Valid shift register tracks which cycles carry a row read.
        vld_d[0] = issue;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
        if (abort) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            end_q       <= 1'b0;
            rows_left_q <= '0;
            addr_q      <= '0;
            settle_q    <= '0;
            drain_q     <= '0;
            vld_q       <= '0;
        end else begin
            state_q     <= state_d;
            end_q       <= end_;
            rows_left_q <= rows_left_d;
            addr_q      <= addr_d;
            settle_q    <= settle_d;
            drain_q     <= drain_d;
            vld_q       <= vld_d;
        end
    end

    // Start-time operand latches and the address shadow pipe are pure data.
    always_ff @(posedge clk) begin
        if (accept) begin
            base_q <= base_address;
`ifdef CHECK_LANE_MASK_EN
            lane_en_q <= lane_enable;
`endif
        end
        addr_pipe_q[0] <= addr_q;
        for (int i = 1; i < READ_LATENCY; i++) begin
            addr_pipe_q[i] <= addr_pipe_q[i-1];
        end
    end

    // -----------------------------------------------------------------------
    // Compare stage: row issued READ_LATENCY cycles ago is on the data buses
    // -----------------------------------------------------------------------
    always_comb begin
        lane_mis = '0;
        for (int k = 0; k < MATRIX_SIZE; k++) begin
            lane_mis[k] = (result_data[k*LANE_W +: LANE_W] !=
                           expected_data[k*LANE_W +: LANE_W]);
        end
`ifdef CHECK_LANE_MASK_EN
        lane_mis = lane_mis & lane_en_q;
`endif
        row_bad = vld_q[READ_LATENCY-1] && (lane_mis != '0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mism_q <= '0;
            ffv_q  <= 1'b0;
            ffa_q  <= '0;
            ffm_q  <= '0;
        end else if (clear_res) begin
            mism_q <= '0;
            ffv_q  <= 1'b0;
            ffa_q  <= '0;
            ffm_q  <= '0;
        end else if (row_bad) begin
            if (mism_q != '1) begin
                mism_q <= mism_q + 1'b1;
            end
            // Only the first failing row is recorded.
            if (!ffv_q) begin
                ffv_q <= 1'b1;
                ffa_q <= addr_pipe_q[READ_LATENCY-1];
                ffm_q <= lane_mis;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign check_address        = addr_q;
    assign busy                 = (state_q == S_SETTLE) || (state_q == S_SCAN) ||
                                  (state_q == S_DRAIN);
    assign done                 = (state_q == S_DONE);
    assign pass                 = (state_q == S_DONE) && (mism_q == '0);
    assign mismatch_count       = mism_q;
    assign first_fail_valid     = ffv_q;
    assign first_fail_address   = ffa_q;
    assign first_fail_lane_mask = ffm_q;

endmodule

// File: tb/tb_vec_mul_result_checker.sv
`timescale 1ns/1ps
module tb_vec_mul_result_checker;

    localparam int AW     = 10;
    localparam int BW     = 24;
    localparam int MS     = 16;
    localparam int RW     = BW * MS;
    localparam int DEPTH  = 1 << AW;
    localparam int SETTLE = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn;
    logic          end_a, end_b, abort_a, abort_b;
    logic [AW-1:0] base_a, base_b;
    logic [AW:0]   rows_a, rows_b;
    logic [MS-1:0] mdl_lane_en;

    logic [RW-1:0] res_mem [DEPTH];
    logic [RW-1:0] exp_mem [DEPTH];
    logic [RW-1:0] rd_res_a, rd_exp_a;
    logic [RW-1:0] rd_res_b [3];
    logic [RW-1:0] rd_exp_b [3];

    logic [AW-1:0] a_addr, b_addr, a_ffa, b_ffa;
    logic          a_busy, a_done, a_pass, a_ffv;
    logic          b_busy, b_done, b_pass, b_ffv;
    logic [AW:0]   a_cnt, b_cnt;
    logic [MS-1:0] a_ffm, b_ffm;

    // Behavioural synchronous memories: one and three cycles of read latency.
    always @(posedge clk) begin
        rd_res_a    <= res_mem[a_addr];
        rd_exp_a    <= exp_mem[a_addr];
        rd_res_b[0] <= res_mem[b_addr];
        rd_exp_b[0] <= exp_mem[b_addr];
        rd_res_b[1] <= rd_res_b[0];
        rd_exp_b[1] <= rd_exp_b[0];
        rd_res_b[2] <= rd_res_b[1];
        rd_exp_b[2] <= rd_exp_b[1];
    end

    vec_mul_result_checker #(.READ_LATENCY(1)) dut_a (
        .clk(clk), .rstn(rstn), .end_(end_a), .abort(abort_a),
        .base_address(base_a), .row_count(rows_a),
`ifdef CHECK_LANE_MASK_EN
        .lane_enable(mdl_lane_en),
`endif
        .check_address(a_addr), .result_data(rd_res_a), .expected_data(rd_exp_a),
        .busy(a_busy), .done(a_done), .pass(a_pass), .mismatch_count(a_cnt),
        .first_fail_valid(a_ffv), .first_fail_address(a_ffa),
        .first_fail_lane_mask(a_ffm)
    );

    vec_mul_result_checker #(.READ_LATENCY(3)) dut_b (
        .clk(clk), .rstn(rstn), .end_(end_b), .abort(abort_b),
        .base_address(base_b), .row_count(rows_b),
`ifdef CHECK_LANE_MASK_EN
        .lane_enable(mdl_lane_en),
`endif
        .check_address(b_addr), .result_data(rd_res_b[2]), .expected_data(rd_exp_b[2]),
        .busy(b_busy), .done(b_done), .pass(b_pass), .mismatch_count(b_cnt),
        .first_fail_valid(b_ffv), .first_fail_address(b_ffa),
        .first_fail_lane_mask(b_ffm)
    );

    // Observation mux: sel picks which instance the current test drives.
    logic          sel;
    wire [AW-1:0]  o_addr = sel ? b_addr : a_addr;
    wire           o_busy = sel ? b_busy : a_busy;
    wire           o_done = sel ? b_done : a_done;
    wire           o_pass = sel ? b_pass : a_pass;
    wire [AW:0]    o_cnt  = sel ? b_cnt  : a_cnt;
    wire           o_ffv  = sel ? b_ffv  : a_ffv;
    wire [AW-1:0]  o_ffa  = sel ? b_ffa  : a_ffa;
    wire [MS-1:0]  o_ffm  = sel ? b_ffm  : a_ffm;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_end(input logic v);
        if (sel) end_b = v; else end_a = v;
    endtask

    task automatic set_abort(input logic v);
        if (sel) abort_b = v; else abort_a = v;
    endtask

    task automatic restore_mem();
        for (int i = 0; i < DEPTH; i++) res_mem[i] = exp_mem[i];
    endtask

    task automatic corrupt(input int a, input int lane);
        logic [BW-1:0] x;
        x = BW'($urandom_range(1, (1 << BW) - 1));
        res_mem[a][lane*BW +: BW] = res_mem[a][lane*BW +: BW] ^ x;
    endtask

    // Reference: scan the first `rows` rows from base straight out of the
    // memory arrays and tally what the checker should report.
    task automatic model(input int base, input int rows, output int cnt,
                         output int ffv, output int ffa, output int ffm);
        cnt = 0; ffv = 0; ffa = 0; ffm = 0;
        for (int i = 0; i < rows; i++) begin
            int a;
            int m;
            a = (base + i) % DEPTH;
            m = 0;
            for (int k = 0; k < MS; k++) begin
                if (mdl_lane_en[k] && (res_mem[a][k*BW +: BW] != exp_mem[a][k*BW +: BW]))
                    m = m | (1 << k);
            end
            if (m != 0) begin
                if (cnt < (1 << (AW + 1)) - 1) cnt++;
                if (ffv == 0) begin
                    ffv = 1; ffa = a; ffm = m;
                end
            end
        end
    endtask

    // mode: 0 plain run, 1 second end_ edge at cycle evt, 2 abort at evt,
    //       3 rstn pulse at evt. Cycle n counts from the edge that sees end_.
    task automatic run(input int base, input int rows, input int mode, input int evt);
        int rl, done_n, cnt, ffv, ffa, ffm, n;
        int pc, pv, pa, pm;
        bit fin;
        rl     = sel ? 3 : 1;
        done_n = (rows == 0) ? 0 : SETTLE + rows + rl;
        model(base, rows, cnt, ffv, ffa, ffm);
        @(negedge clk);
        if (sel) begin base_b = AW'(base); rows_b = (AW+1)'(rows); end
        else     begin base_a = AW'(base); rows_a = (AW+1)'(rows); end
        set_end(1'b1);
        @(posedge clk);
        n = 0;
        fin = 0;
        while (!fin) begin
            @(negedge clk);
            if (n == 0) begin
                set_end(1'b0);
                if (rows != 0) begin
                    chk("busy_after_start", o_busy, 1);
                    chk("count_cleared", o_cnt, 0);
                    chk("ffv_cleared", o_ffv, 0);
                end
            end
            if (rows != 0 && n >= SETTLE && n < SETTLE + rows)
                chk("scan_addr", o_addr, (base + n - SETTLE) % DEPTH);
            if (mode == 1 && n == evt) set_end(1'b1);
            if (mode == 1 && n == evt + 1) set_end(1'b0);
            if (mode == 2 && n == evt) begin
                model(base, evt - SETTLE - rl, pc, pv, pa, pm);
                chk("pre_abort_count", o_cnt, pc);
                chk("pre_abort_ffv", o_ffv, pv);
                set_abort(1'b1);
            end else if (mode == 2 && n == evt + 1) begin
                set_abort(1'b0);
                chk("abort_busy", o_busy, 0);
                chk("abort_done", o_done, 0);
                chk("abort_pass", o_pass, 0);
                chk("abort_count", o_cnt, 0);
                chk("abort_ffv", o_ffv, 0);
                fin = 1;
            end else if (mode == 3 && n == evt) begin
                rstn = 1'b0;
                #1;
                chk("rst_addr", o_addr, 0);
                chk("rst_busy", o_busy, 0);
                chk("rst_done", o_done, 0);
                chk("rst_pass", o_pass, 0);
                chk("rst_count", o_cnt, 0);
                chk("rst_ffv", o_ffv, 0);
                chk("rst_ffa", o_ffa, 0);
                chk("rst_ffm", o_ffm, 0);
                @(negedge clk);
                rstn = 1'b1;
                fin = 1;
            end else if (o_done) begin
                chk("done_cycle", n, done_n);
                chk("done_busy", o_busy, 0);
                chk("pass", o_pass, (cnt == 0) ? 1 : 0);
                chk("mismatch_count", o_cnt, cnt);
                chk("first_fail_valid", o_ffv, ffv);
                chk("first_fail_address", o_ffa, ffa);
                chk("first_fail_lane_mask", o_ffm, ffm);
                repeat (3) @(negedge clk);
                chk("done_hold", o_done, 1);
                chk("count_hold", o_cnt, cnt);
                if (rows != 0) chk("addr_hold", o_addr, (base + rows - 1) % DEPTH);
                fin = 1;
            end else if (n > done_n + 20) begin
                chk("done_timeout", n, done_n);
                fin = 1;
            end
            n++;
        end
    endtask

    initial begin
        rstn = 1'b0; sel = 1'b0;
        end_a = 1'b0; end_b = 1'b0; abort_a = 1'b0; abort_b = 1'b0;
        base_a = '0; base_b = '0; rows_a = '0; rows_b = '0;
        mdl_lane_en = '1;
        for (int i = 0; i < DEPTH; i++)
            for (int k = 0; k < MS; k++)
                exp_mem[i][k*BW +: BW] = BW'($urandom);
        restore_mem();

        repeat (3) @(negedge clk);
        chk("reset_addr", a_addr, 0);
        chk("reset_busy", a_busy, 0);
        chk("reset_done", a_done, 0);
        chk("reset_pass", a_pass, 0);
        chk("reset_count", a_cnt, 0);
        chk("reset_ffv", a_ffv, 0);
        chk("reset_ffa", a_ffa, 0);
        chk("reset_ffm", a_ffm, 0);
        rstn = 1'b1;
        @(negedge clk);

        // Matching data.
        run(0, 16, 0, 0);

        // Two bad rows: row 5 lane 3, row 9 lanes 0 and 15.
        corrupt(5, 3);
        corrupt(9, 0);
        corrupt(9, 15);
        run(0, 16, 0, 0);

        // Second end_ edge while busy changes nothing.
        run(0, 16, 1, 6);

        // Fresh start after done on clean data clears the old results.
        restore_mem();
        run(0, 16, 0, 0);

        // Zero rows.
        run(int'($urandom_range(0, DEPTH - 1)), 0, 0, 0);

        // Abort and reset at scan row 7 after one captured mismatch.
        corrupt(5, 3);
        run(0, 16, 2, SETTLE + 7);
        run(0, 16, 3, SETTLE + 7);
        restore_mem();

        // Longer read latency with address wrap; error at wrapped address 2.
        sel = 1'b1;
        corrupt(2, int'($urandom_range(0, MS - 1)));
        run(1020, 8, 0, 0);
        restore_mem();

        // Randomised runs on both instances.
        for (int it = 0; it < 8; it++) begin
            int base, rows, nbad;
            sel  = it[0];
            base = int'($urandom_range(0, DEPTH - 1));
            rows = int'($urandom_range(1, 40));
            nbad = int'($urandom_range(0, 3));
            for (int j = 0; j < nbad; j++)
                corrupt((base + int'($urandom_range(0, rows - 1))) % DEPTH,
                        int'($urandom_range(0, MS - 1)));
            run(base, rows, 0, 0);
            restore_mem();
        end

`ifdef CHECK_LANE_MASK_EN
        sel = 1'b0;
        mdl_lane_en = 16'hFFF7;
        corrupt(4, 3);
        run(0, 16, 0, 0);
        mdl_lane_en = '1;
        restore_mem();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
